// File: rtl/convertidor_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: result and valido appear ANCHO cycles after the edge that accepts inicio.
// Backpressure: none; inicio is ignored while ocupado=1, and the result is held until the next FIN.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   inicio     start request, accepted in REPOSO or FIN
//   n_binario  unsigned value, captured on an accepted start
//   ocupado    high while shifting
//   valido     one-cycle pulse when bcd/desborde carry a new result
//   bcd        DIGITOS packed BCD digits, digit 0 in bits [3:0]
//   desborde   value did not fit in DIGITOS digits (bcd then reads all nines)
module convertidor_bcd_secuencial #(
    parameter int ANCHO   = 10,
    parameter int DIGITOS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inicio,
    input  logic [ANCHO-1:0]       n_binario,
    output logic                   ocupado,
    output logic                   valido,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   desborde
);

    localparam int ACC_W = 4 * DIGITOS;
    localparam int CNT_W = $clog2(ANCHO + 1);

    // Saturated value presented when the result overflows the digit count.
    localparam logic [ACC_W-1:0] TODO_NUEVES = {DIGITOS{4'h9}};

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [ANCHO-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               desborde_q, desborde_d;

    // Accumulator after the per-digit add-3 correction, and after the shift.
    logic [ACC_W-1:0]   acc_ajust;
    logic [ACC_W-1:0]   acc_desp;
    logic [ANCHO-1:0]   bin_desp;
    logic               ultimo;

    // Each digit is corrected independently; a digit >= 5 becomes >= 8 so the
    // following shift carries it into the next digit. No inter-digit carry.
    for (genvar k = 0; k < DIGITOS; k++) begin : g_digito
        assign acc_ajust[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? (acc_q[4*k +: 4] + 4'd3)
                                                               : acc_q[4*k +: 4];
    end

    // {acc, bin} shifted left by one: the binary MSB enters the units digit.
    assign acc_desp = {acc_ajust[ACC_W-2:0], bin_q[ANCHO-1]};
    assign bin_desp = bin_q << 1;

    // cnt_q counts completed shifts, so the shift in progress is the last one
    // when ANCHO-1 shifts are already done.
    assign ultimo = (cnt_q == CNT_W'(ANCHO - 1));

    always_comb begin
        estado_d   = estado_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        desborde_d = desborde_q;

        case (estado_q)
            REPOSO, FIN: begin
                if (inicio) begin
                    bin_d    = n_binario;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    estado_d = DESPLAZA;
                end else begin
                    estado_d = REPOSO;
                end
            end

            DESPLAZA: begin
                acc_d = acc_desp;
                bin_d = bin_desp;
                cnt_d = cnt_q + CNT_W'(1);
                // A set MSB after correction is about to be shifted out of
                // the accumulator, i.e. the value no longer fits.
                ovf_d = ovf_q | acc_ajust[ACC_W-1];
                if (ultimo) begin
                    estado_d = FIN;
                    if (ovf_d) begin
                        bcd_d      = TODO_NUEVES;
                        desborde_d = 1'b1;
                    end else begin
                        bcd_d      = acc_desp;
                        desborde_d = 1'b0;
                    end
                end
            end

            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= REPOSO;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            desborde_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            desborde_q <= desborde_d;
        end
    end

    assign ocupado  = (estado_q == DESPLAZA);
    assign valido   = (estado_q == FIN);
    assign bcd      = bcd_q;
    assign desborde = desborde_q;

endmodule

// File: tb/tb_convertidor_bcd_secuencial.sv
module tb_convertidor_bcd_secuencial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: defaults (10 bits, 4 digits)
    logic        inicio_a = 1'b0;
    logic [9:0]  n_a = '0;
    logic        ocupado_a, valido_a, desborde_a;
    logic [15:0] bcd_a;
    // Instance b: 10 bits, 3 digits
    logic        inicio_b = 1'b0;
    logic [9:0]  n_b = '0;
    logic        ocupado_b, valido_b, desborde_b;
    logic [11:0] bcd_b;
    // Instance c: 16 bits, 5 digits
    logic        inicio_c = 1'b0;
    logic [15:0] n_c = '0;
    logic        ocupado_c, valido_c, desborde_c;
    logic [19:0] bcd_c;

    convertidor_bcd_secuencial #(.ANCHO(10), .DIGITOS(4)) u_a (
        .clk(clk), .rst_n(rst_n), .inicio(inicio_a), .n_binario(n_a),
        .ocupado(ocupado_a), .valido(valido_a), .bcd(bcd_a), .desborde(desborde_a));
    convertidor_bcd_secuencial #(.ANCHO(10), .DIGITOS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .inicio(inicio_b), .n_binario(n_b),
        .ocupado(ocupado_b), .valido(valido_b), .bcd(bcd_b), .desborde(desborde_b));
    convertidor_bcd_secuencial #(.ANCHO(16), .DIGITOS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .inicio(inicio_c), .n_binario(n_c),
        .ocupado(ocupado_c), .valido(valido_c), .bcd(bcd_c), .desborde(desborde_c));

    typedef struct {
        logic [39:0] bcd;
        logic        des;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int which, input logic [39:0] b, input logic d, input int at);
        exp_t e;
        e.bcd = b;
        e.des = d;
        e.cyc = at;
        case (which)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // All start tasks are entered at a negedge; they return at the negedge
    // after the accepting edge. Result is expected with cyc = c + ANCHO + 1.
    task automatic start_a(input logic [9:0] n, input logic [15:0] b, input logic d);
        inicio_a = 1'b1;
        n_a = n;
        push(0, 40'(b), d, cyc + 11);
        @(negedge clk);
        inicio_a = 1'b0;
        n_a = ~n;
    endtask

    task automatic start_b(input logic [9:0] n, input logic [11:0] b, input logic d);
        inicio_b = 1'b1;
        n_b = n;
        push(1, 40'(b), d, cyc + 11);
        @(negedge clk);
        inicio_b = 1'b0;
    endtask

    task automatic start_c(input logic [15:0] n, input logic [19:0] b, input logic d);
        inicio_c = 1'b1;
        n_c = n;
        push(2, 40'(b), d, cyc + 17);
        @(negedge clk);
        inicio_c = 1'b0;
    endtask

    // Monitors: pop and compare whenever an instance presents valido.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valido_a) begin
            if (q_a.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL a_unexpected_valido: got bcd %0h at cyc %0d, expected no result", bcd_a, cyc);
            end else begin
                e = q_a.pop_front();
                chk("a_bcd", 64'(bcd_a), 64'(e.bcd[15:0]));
                chk("a_desborde", 64'(desborde_a), 64'(e.des));
                chk("a_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valido_b) begin
            if (q_b.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL b_unexpected_valido: got bcd %0h at cyc %0d, expected no result", bcd_b, cyc);
            end else begin
                e = q_b.pop_front();
                chk("b_bcd", 64'(bcd_b), 64'(e.bcd[11:0]));
                chk("b_desborde", 64'(desborde_b), 64'(e.des));
                chk("b_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valido_c) begin
            if (q_c.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL c_unexpected_valido: got bcd %0h at cyc %0d, expected no result", bcd_c, cyc);
            end else begin
                e = q_c.pop_front();
                chk("c_bcd", 64'(bcd_c), 64'(e.bcd[19:0]));
                chk("c_desborde", 64'(desborde_c), 64'(e.des));
                chk("c_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int busy;

        // Reset state
        @(negedge clk);
        chk("rst_ocupado", 64'(ocupado_a), 64'd0);
        chk("rst_valido", 64'(valido_a), 64'd0);
        chk("rst_bcd", 64'(bcd_a), 64'd0);
        chk("rst_desborde", 64'(desborde_a), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 999 with ocupado counted over the conversion window
        start_a(10'd999, 16'h0999, 1'b0);
        busy = 0;
        for (int i = 0; i < 12; i++) begin
            if (ocupado_a) busy++;
            @(negedge clk);
        end
        chk("ocupado_cycles", 64'(busy), 64'd10);
        repeat (2) @(negedge clk);

        // 1023 then 0; bcd must hold 1023 while the second conversion runs
        c = cyc;
        start_a(10'd1023, 16'h1023, 1'b0);
        wait_cyc(c + 14);
        c = cyc;
        start_a(10'd0, 16'h0000, 1'b0);
        wait_cyc(c + 5);
        chk("hold_bcd_mid", 64'(bcd_a), 64'h1023);
        wait_cyc(c + 14);

        // inicio held high: 5, 512, 37 back-to-back, one result every 11 cycles
        c = cyc;
        inicio_a = 1'b1;
        n_a = 10'd5;
        push(0, 40'h0005, 1'b0, c + 11);
        wait_cyc(c + 1);
        n_a = 10'd512;
        push(0, 40'h0512, 1'b0, c + 22);
        wait_cyc(c + 12);
        n_a = 10'd37;
        push(0, 40'h0037, 1'b0, c + 33);
        wait_cyc(c + 23);
        inicio_a = 1'b0;
        wait_cyc(c + 37);

        // Pulse on inicio while busy yields no extra result
        c = cyc;
        start_a(10'd300, 16'h0300, 1'b0);
        wait_cyc(c + 4);
        inicio_a = 1'b1;
        n_a = 10'd77;
        @(negedge clk);
        inicio_a = 1'b0;
        wait_cyc(c + 25);

        // Asynchronous reset at shift 5 of a conversion of 700
        c = cyc;
        start_a(10'd700, 16'h0700, 1'b0);
        wait_cyc(c + 6);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_bcd", 64'(bcd_a), 64'd0);
        chk("arst_ocupado", 64'(ocupado_a), 64'd0);
        chk("arst_valido", 64'(valido_a), 64'd0);
        chk("arst_desborde", 64'(desborde_a), 64'd0);
        void'(q_a.pop_back());
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        c = cyc;
        start_a(10'd700, 16'h0700, 1'b0);
        wait_cyc(c + 14);

        // Three digits: 1000 saturates, 999 fits exactly
        c = cyc;
        start_b(10'd1000, 12'h999, 1'b1);
        wait_cyc(c + 14);
        c = cyc;
        start_b(10'd999, 12'h999, 1'b0);
        wait_cyc(c + 14);

        // 16 bits, 5 digits: full-scale input
        c = cyc;
        start_c(16'd65535, 20'h65535, 1'b0);
        wait_cyc(c + 20);

        repeat (3) @(negedge clk);
        chk("a_pending", 64'(q_a.size()), 64'd0);
        chk("b_pending", 64'(q_b.size()), 64'd0);
        chk("c_pending", 64'(q_c.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
